logic_pod_sample_packer: RTL and testbench
==========================================

LOGIC_POD_SAMPLE_PACKER -- requirements
Module: logic_pod_sample_packer

Interface
REQ-001 SHALL have parameter CHANNELS, default 8: number of logic channels sampled per beat.
REQ-002 SHALL have parameter SAMPLES, default 4: samples per channel per input beat.
REQ-003 SHALL have parameter RATIO, default 2: input beats packed per output word, range 1..16.
REQ-004 SHALL have parameter DEPTH, default 8: output FIFO depth in words, power of 2, minimum 2.
REQ-005 SHALL use one clock and a synchronous, active-high reset, named as follows.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port din, input, CHANNELS*SAMPLES bits: one input beat; channel c occupies bits [c*SAMPLES +: SAMPLES].
REQ-009 SHALL have port din_valid, input, 1 bit: din carries a beat this cycle; there is no backpressure.
REQ-010 SHALL have port decim, input, 8 bits: keep one beat out of every decim+1 valid beats.
REQ-011 SHALL have port flush, input, 1 bit: single-cycle pulse that closes a partially packed word.
REQ-012 SHALL have port dout, output, CHANNELS*SAMPLES*RATIO bits: head-of-FIFO word.
REQ-013 SHALL have port dout_valid, output, 1 bit: FIFO not empty.
REQ-014 SHALL have port dout_ready, input, 1 bit: consumer accepts dout when dout_valid and dout_ready are both high.
REQ-015 SHALL have port fill, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-016 SHALL have port overflow, output, 1 bit: sticky; a packed word was dropped.

Function
REQ-017 Decimator: an 8-bit skip counter increments on each valid beat; a beat is kept when counter >= decim, and the counter then clears to 0; with decim=0 every valid beat is kept.
REQ-018 A decim change takes effect on the next valid beat without clearing the counter; the >= comparison bounds the resulting gap.
REQ-019 Packer: kept beats fill slots 0..RATIO-1 in order; slot k occupies dout bits [k*CHANNELS*SAMPLES +: CHANNELS*SAMPLES], so the first-kept beat lands in the LSBs.
REQ-020 When slot RATIO-1 is filled, the assembled word SHALL be pushed to the FIFO on the next clock edge; the slot index returns to 0, so back-to-back kept beats lose no data.
REQ-021 Flush with slot index > 0: push the partial word with unfilled slots zero; slot index resets to 0.
REQ-022 Flush with slot index 0: no effect; no empty word is pushed.
REQ-023 Flush coincident with a kept beat: include that beat first, then push, so a single word is produced.
REQ-024 FIFO: DEPTH words, first-word-fall-through; dout is valid in the same cycle dout_valid is high.
REQ-025 Latency: a word completed on edge N appears with dout_valid=1 after edge N+1 when the FIFO was empty.
REQ-026 Push into a full FIFO: drop the word, set overflow, leave FIFO contents and fill unchanged.
REQ-027 Simultaneous push and pop while full: the pop frees the entry, the push succeeds, no overflow, fill unchanged.
REQ-028 Simultaneous push and pop at any other occupancy: fill unchanged.
REQ-029 Pop when empty is ignored; dout value is don't-care while dout_valid=0.
REQ-030 Read and write pointers wrap modulo DEPTH; fill is computed exactly, from 0 to DEPTH inclusive.
REQ-031 overflow clears only on rst.

Reset
REQ-032 On rst: skip counter=0, slot index=0, packing register=0, FIFO pointers=0, fill=0, dout_valid=0, overflow=0.
REQ-033 Reset mid-word SHALL discard the partial word; a beat presented in the reset cycle is ignored.
REQ-034 After rst falls, the first valid beat SHALL be accepted on the next edge.
REQ-035 Storage RAM contents are not reset; dout=0 is not guaranteed after reset.

Verification
REQ-036 Defaults, decim=0, beats 0x11111111 then 0x22222222, ready=1 -> dout=0x2222222211111111, dout_valid high for one cycle, fill returns to 0.
REQ-037 decim=2, 6 consecutive beats 1..6 -> one word is output holding beats 3 (LSBs) and 6.
REQ-038 Beat 0xAAAAAAAA, then flush 3 cycles later -> dout=0x00000000AAAAAAAA; a second flush produces no word.
REQ-039 ready=0, 2*(DEPTH+1) beats -> fill=8, overflow=1, the 9th word is lost; draining yields words 1..8 in order.
REQ-040 FIFO full, ready=1, complete a word in the same cycle -> overflow stays 0, fill stays 8.
REQ-041 rst after one beat of a word, then beats B and C -> first output word is {C,B}.

Source files
------------

// File: rtl/logic_pod_sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : logic_pod_sample_packer
// Purpose  : Decimates logic-analyser sample beats, packs RATIO kept beats
//            into one wide word and queues words in a first-word-fall-through
//            FIFO with a sticky overflow flag.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            din, din_valid  - input beat (channel c at [c*SAMPLES +: SAMPLES])
//            decim           - keep one of every decim+1 valid beats
//            flush           - close a partially packed word
//            dout, dout_valid, dout_ready - FIFO head and handshake
//            fill            - FIFO occupancy, 0..DEPTH
//            overflow        - sticky, a packed word was dropped
// Revision : 1.0 - initial release
// ============================================================================
module logic_pod_sample_packer #(
  parameter int CHANNELS = 8,
  parameter int SAMPLES  = 4,
  parameter int RATIO    = 2,
  parameter int DEPTH    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CHANNELS*SAMPLES-1:0]          din,
  input  logic                                 din_valid,
  input  logic [7:0]                           decim,
  input  logic                                 flush,
  output logic [CHANNELS*SAMPLES*RATIO-1:0]    dout,
  output logic                                 dout_valid,
  input  logic                                 dout_ready,
  output logic [$clog2(DEPTH):0]               fill,
  output logic                                 overflow
);

  localparam int BEAT_W = CHANNELS * SAMPLES;
  localparam int WORD_W = BEAT_W * RATIO;
  localparam int SLOT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(RATIO - 1);
  localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // Decimator and packer
  // --------------------------------------------------------------------------
  logic [7:0]        skip_cnt;
  logic [SLOT_W-1:0] slot;
  logic [WORD_W-1:0] pack;
  logic [WORD_W-1:0] stage_word;
  logic              stage_valid;

  logic              keep;
  logic              close_word;
  logic [WORD_W-1:0] merged;

  // >= rather than == so that lowering decim mid-gap keeps the next beat
  // instead of waiting for the 8-bit counter to wrap.
  assign keep = din_valid && (skip_cnt >= decim);

  always_comb begin
    merged = pack;
    if (keep) begin
      merged[slot*BEAT_W +: BEAT_W] = din;
    end
  end

  // A word closes when its last slot fills, or on flush if it holds (or is
  // about to hold) at least one beat; an empty flush is a no-op.
  assign close_word = (keep && (slot == LAST_SLOT)) ||
                      (flush && (keep || (slot != '0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_cnt    <= '0;
      slot        <= '0;
      pack        <= '0;
      stage_word  <= '0;
      stage_valid <= 1'b0;
    end else begin
      if (din_valid) begin
        skip_cnt <= keep ? 8'd0 : skip_cnt + 8'd1;
      end

      // The completed word is staged for one cycle, then written to the FIFO.
      stage_valid <= close_word;
      if (close_word) begin
        stage_word <= merged;
      end

      // Clearing the packing register on close guarantees zero-filled
      // unused slots in the next (possibly partial) word.
      if (close_word) begin
        pack <= '0;
        slot <= '0;
      end else if (keep) begin
        pack <= merged;
        slot <= slot + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // --------------------------------------------------------------------------
  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  logic full;
  logic pop;
  logic wr_en;

  assign full  = (count == FULL_COUNT);
  assign pop   = dout_ready && (count != '0);
  // A concurrent pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en = stage_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr] <= stage_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (stage_valid && !wr_en) begin
        overflow <= 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout       = mem[rd_ptr];
  assign dout_valid = (count != '0);
  assign fill       = count;

endmodule
`default_nettype wire

// File: tb/tb_logic_pod_sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_pod_sample_packer
// Purpose  : Directed self-checking bench for logic_pod_sample_packer with
//            default parameters (32-bit beats, 64-bit words, 8-deep FIFO).
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_pod_sample_packer;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        din_valid;
  logic [7:0]  decim;
  logic        flush;
  logic [63:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [3:0]  fill;
  logic        overflow;

  int total;
  int bad;

  logic_pod_sample_packer dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .decim      (decim),
    .flush      (flush),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .fill       (fill),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d);
    din       = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    decim      = 8'd0;
    flush      = 1'b0;
    dout_ready = 1'b0;
    tick();
    do_reset();
    check("rst_fill", 64'(fill), 64'd0);
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);

    // Two beats form one word; one cycle of staging latency; popped at once.
    dout_ready = 1'b1;
    beat(32'h11111111);
    beat(32'h22222222);
    check("lat_not_yet", 64'(dout_valid), 64'd0);
    tick();
    check("pair_valid", 64'(dout_valid), 64'd1);
    check("pair_dout", dout, 64'h2222222211111111);
    tick();
    check("pair_popped", 64'(dout_valid), 64'd0);
    check("pair_fill0", 64'(fill), 64'd0);

    // decim=2 keeps beats 3 and 6.
    dout_ready = 1'b0;
    decim = 8'd2;
    for (int i = 1; i <= 6; i++) beat(32'(i));
    tick();
    check("decim_fill", 64'(fill), 64'd1);
    check("decim_dout", dout, 64'h0000000600000003);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    decim = 8'd0;
    check("decim_drain", 64'(fill), 64'd0);

    // Partial word closed by flush; a second flush is a no-op.
    beat(32'hAAAAAAAA);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("flush_fill", 64'(fill), 64'd1);
    check("flush_dout", dout, 64'h00000000AAAAAAAA);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    check("flush_empty", 64'(fill), 64'd0);

    // Flush coincident with the beat completing slot 1: exactly one word.
    beat(32'h00000077);
    flush = 1'b1;
    beat(32'h00000088);
    flush = 1'b0;
    tick();
    tick();
    check("flushbeat_fill", 64'(fill), 64'd1);
    check("flushbeat_dout", dout, 64'h0000008800000077);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;

    // Overfill: 9 words into an 8-deep FIFO, the 9th is dropped.
    for (int i = 0; i < 18; i++) beat(32'h1000 + 32'(i));
    tick();
    tick();
    check("ovf_fill", 64'(fill), 64'd8);
    check("ovf_flag", 64'(overflow), 64'd1);
    dout_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_%0d", k), dout,
            {32'h1000 + 32'(2*k+1), 32'h1000 + 32'(2*k)});
      tick();
    end
    dout_ready = 1'b0;
    check("drain_empty", 64'(dout_valid), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Full FIFO with push and pop on the same edge: no overflow.
    do_reset();
    check("rst2_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 16; i++) beat(32'h2000 + 32'(i));
    tick();
    tick();
    check("full_fill", 64'(fill), 64'd8);
    beat(32'hBEEF0001);
    beat(32'hBEEF0002);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("pp_fill", 64'(fill), 64'd8);
    check("pp_ovf", 64'(overflow), 64'd0);
    check("pp_head", dout, 64'h0000200300002002);
    dout_ready = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    dout_ready = 1'b0;
    check("pp_last_fill", 64'(fill), 64'd1);
    check("pp_last_dout", dout, 64'hBEEF0002BEEF0001);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;

    // Reset mid-word discards the partial word and the reset-cycle beat.
    beat(32'hDEAD0000);
    din       = 32'hDEAD0001;
    din_valid = 1'b1;
    do_reset();
    din_valid = 1'b0;
    beat(32'h0000000B);
    beat(32'h0000000C);
    tick();
    check("rstmid_fill", 64'(fill), 64'd1);
    check("rstmid_dout", dout, 64'h0000000C0000000B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
